regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port list (name  direction  width  meaning) SHALL be exactly:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset (0 = reset)
- alu_valid  in  1  execute-stage writeback request (ALU result or JAL link)
- alu_addr  in  5  destination register
- alu_data  in  32  write data
- alu_ready  out  1  request accepted this cycle when high with alu_valid
- ld_issue  in  1  load/IO read issued; destination recorded
- ld_addr  in  5  load destination register
- ld_full  out  1  load-tag FIFO full
- ld_valid  in  1  load/IO data return, in issue order, no backpressure
- ld_data  in  32  returned data
- rs_addr  in  5  decode-stage source 1
- rt_addr  in  5  decode-stage source 2
- hazard  out  1  decode must stall
- pending  out  32  scoreboard: bit i set while a load to register i is outstanding
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  5  register-file write address (registered)
- wr_data  out  32  register-file write data (registered)
- err  out  1  sticky protocol-error flag

Function
REQ-003 The load-tag FIFO SHALL be 4 entries deep and in order; ld_issue enqueues ld_addr; ld_valid dequeues the head.
REQ-004 ld_full SHALL be high when 4 entries are valid; ld_issue while full SHALL be dropped and SHALL set err.
REQ-005 ld_valid with the FIFO empty SHALL be ignored and SHALL set err.
REQ-006 Simultaneous ld_issue and ld_valid with the FIFO full SHALL both take effect (dequeue and enqueue); the count stays 4 and err is not set.
REQ-007 pending[i] SHALL be the combinational OR over valid FIFO entries whose address equals i; pending[0] SHALL always be 0.
REQ-008 There SHALL be a 1-entry skid buffer (addr, data) for ALU writebacks that lose arbitration.
REQ-009 alu_ready SHALL equal (skid empty) AND NOT pending[alu_addr], so ALU writes cannot overtake older loads to the same register.
REQ-010 Write-port priority each cycle SHALL be: load return (ld_valid with FIFO non-empty) > skid entry > newly accepted ALU request.
REQ-011 An accepted ALU request that loses to a load return SHALL move into the skid buffer.
REQ-012 With skid full and no load return, the skid entry SHALL be written and the skid buffer emptied.
REQ-013 The winner SHALL appear on wr_en/wr_addr/wr_data on the next rising edge (latency 1 cycle); wr_en SHALL be 0 in cycles with no winner.
REQ-014 A winner addressed to register 0 SHALL consume its slot, but wr_en SHALL stay 0.
REQ-015 hazard SHALL be high when a nonzero rs_addr or rt_addr has its pending bit set, or equals a full skid buffer's address.
REQ-016 hazard SHALL also be high when a nonzero rs_addr or rt_addr equals wr_addr while wr_en is high, covering the write-then-read cycle.
REQ-017 Load data SHALL be written to the head-entry address captured at issue, not to any current input address.

Reset
REQ-018 While reset=0, the block SHALL asynchronously force:
- FIFO empty
- skid buffer empty
- wr_en=0, wr_addr=0, wr_data=0
- err=0, pending=0
- alu_ready, ld_full and hazard to their reset-state values: alu_ready=1 when alu_addr is not pending, ld_full=0, hazard=0
REQ-019 Reset asserted mid-operation SHALL discard outstanding load tags and skid contents; load returns arriving after release are treated per REQ-005.

Verification
REQ-020 Plain ALU path: alu_valid=1, alu_addr=5, alu_data=0x1234 -> next cycle wr_en=1, wr_addr=5, wr_data=0x1234; alu_ready=1.
REQ-021 Collision: ld_issue(addr 7); later same cycle ld_valid (data 0xAA) and alu_valid (addr 3, data 0xBB) -> cycle+1 writes r7=0xAA and alu_ready=0; cycle+2 writes r3=0xBB; pending[7] falls after the dequeue.
REQ-022 Scoreboard/hazard: ld_issue addr 9, then rs_addr=9 -> hazard=1 and pending[9]=1 until the return; alu_valid with alu_addr=9 -> alu_ready=0 until the return.
REQ-023 FIFO limits: 4 issues (1, 2, 3, 4) -> ld_full=1; 5th issue -> dropped, err=1; 4 returns are written to r1..r4 in order; an extra ld_valid -> no write.
REQ-024 Register 0: alu_addr=0 and ld_issue addr 0 with return -> wr_en never asserted; pending=0; hazard=0 for rs_addr=0.
REQ-025 Reset mid-flight: 2 loads outstanding plus skid full, then reset=0 -> all outputs cleared immediately without waiting for a clock edge; after release, ld_valid -> err=1, no write.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Single write port arbiter for a register file shared by an execute-stage
// writeback path (ALU result / JAL link) and an in-order load/IO return path.
// A 4-entry load-tag FIFO records the destination of every issued load. Its
// live entries form the "pending" scoreboard that stalls decode and blocks
// ALU writes that would overtake an older load to the same register. A one
// entry skid buffer holds an ALU writeback that loses the port to a load
// return.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = reset)
//   alu_valid  in   ALU writeback request
//   alu_addr   in   [4:0]  ALU destination register
//   alu_data   in   [31:0] ALU write data
//   alu_ready  out  ALU request accepted when high together with alu_valid
//   ld_issue   in   load issued, ld_addr enqueued as its tag
//   ld_addr    in   [4:0]  load destination register
//   ld_full    out  load-tag FIFO holds 4 entries
//   ld_valid   in   load data return (in issue order, no backpressure)
//   ld_data    in   [31:0] returned load data
//   rs_addr    in   [4:0]  decode source 1
//   rt_addr    in   [4:0]  decode source 2
//   hazard     out  decode must stall
//   pending    out  [31:0] bit i set while a load to register i is in flight
//   wr_en      out  registered register-file write enable
//   wr_addr    out  [4:0]  registered register-file write address
//   wr_data    out  [31:0] registered register-file write data
//   err        out  sticky protocol-error flag (overflow / underflow)
// ---------------------------------------------------------------------------
module regfile_write_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_addr,
    output logic        ld_full,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        hazard,
    output logic [31:0] pending,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        err
);

    // Load-tag FIFO storage: circular buffer with head pointer and count.
    logic [4:0]  tag_addr_r [0:3];
    logic [1:0]  head_r;
    logic [2:0]  count_r;
    logic [2:0]  count_next_s;
    logic [1:0]  tail_s;
    logic [3:0]  tag_live_s;

    // Skid buffer for an ALU writeback displaced by a load return.
    logic        skid_valid_r;
    logic [4:0]  skid_addr_r;
    logic [31:0] skid_data_r;

    // FIFO / arbitration control.
    logic        ld_deq_s;
    logic        ld_enq_s;
    logic        err_set_s;
    logic        alu_acc_s;
    logic        win_valid_s;
    logic [4:0]  win_addr_s;
    logic [31:0] win_data_s;
    logic        skid_load_s;
    logic        skid_clear_s;
    logic [31:0] pending_s;
    logic        hazard_s;

    // A slot is live when its distance from the head is below the count.
    function automatic logic slot_live(input logic [1:0] slot,
                                       input logic [1:0] head,
                                       input logic [2:0] count);
        logic [1:0] rel;
        rel = slot - head;
        return ({1'b0, rel} < count);
    endfunction

    // A source register is hazardous if a load, the skid entry or the write
    // that is just landing in the register file targets it.
    function automatic logic src_hazard(input logic [4:0]  src,
                                        input logic [31:0] pend,
                                        input logic        skid_v,
                                        input logic [4:0]  skid_a,
                                        input logic        we,
                                        input logic [4:0]  wa);
        logic hit;
        if (src == 5'd0) begin
            hit = 1'b0;
        end else begin
            hit = pend[src] | (skid_v & (skid_a == src)) | (we & (wa == src));
        end
        return hit;
    endfunction

    assign tail_s    = head_r + count_r[1:0];
    assign ld_deq_s  = ld_valid & (count_r != 3'd0);
    // A full FIFO still accepts an issue when the head leaves in the same cycle.
    assign ld_enq_s  = ld_issue & ((count_r != 3'd4) | ld_deq_s);
    assign err_set_s = (ld_issue & ~ld_enq_s) | (ld_valid & (count_r == 3'd0));

    // Next FIFO occupancy from the enqueue/dequeue pair.
    always_comb begin
        count_next_s = count_r;
        case ({ld_enq_s, ld_deq_s})
            2'b10:   count_next_s = count_r + 3'd1;
            2'b01:   count_next_s = count_r - 3'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Scoreboard: OR of live tag addresses; register 0 never pending.
    always_comb begin
        pending_s  = 32'd0;
        tag_live_s = 4'd0;
        for (int i = 0; i < 4; i++) begin
            tag_live_s[i] = slot_live(2'(i), head_r, count_r);
            if (tag_live_s[i]) begin
                pending_s[tag_addr_r[i]] = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
        pending_s[0] = 1'b0;
    end

    assign pending   = pending_s;
    assign ld_full   = (count_r == 3'd4);
    assign alu_ready = ~skid_valid_r & ~pending_s[alu_addr];
    assign alu_acc_s = alu_valid & alu_ready;

    // Decode stall detection on both source operands.
    always_comb begin
        hazard_s = src_hazard(rs_addr, pending_s, skid_valid_r, skid_addr_r, wr_en, wr_addr)
                 | src_hazard(rt_addr, pending_s, skid_valid_r, skid_addr_r, wr_en, wr_addr);
    end

    assign hazard = hazard_s;

    // Write-port arbitration: load return > skid entry > new ALU request.
    always_comb begin
        win_valid_s  = 1'b0;
        win_addr_s   = 5'd0;
        win_data_s   = 32'd0;
        skid_load_s  = 1'b0;
        skid_clear_s = 1'b0;
        if (ld_deq_s) begin
            // Load data goes to the address captured at issue time.
            win_valid_s = 1'b1;
            win_addr_s  = tag_addr_r[head_r];
            win_data_s  = ld_data;
            skid_load_s = alu_acc_s;
        end else if (skid_valid_r) begin
            win_valid_s  = 1'b1;
            win_addr_s   = skid_addr_r;
            win_data_s   = skid_data_r;
            skid_clear_s = 1'b1;
        end else if (alu_acc_s) begin
            win_valid_s = 1'b1;
            win_addr_s  = alu_addr;
            win_data_s  = alu_data;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Load-tag FIFO state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r  <= 2'd0;
            count_r <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                tag_addr_r[i] <= 5'd0;
            end
        end else begin
            count_r <= count_next_s;
            if (ld_deq_s) begin
                head_r <= head_r + 2'd1;
            end
            if (ld_enq_s) begin
                tag_addr_r[tail_s] <= ld_addr;
            end
        end
    end

    // Skid buffer state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            skid_valid_r <= 1'b0;
            skid_addr_r  <= 5'd0;
            skid_data_r  <= 32'd0;
        end else if (skid_load_s) begin
            skid_valid_r <= 1'b1;
            skid_addr_r  <= alu_addr;
            skid_data_r  <= alu_data;
        end else if (skid_clear_s) begin
            skid_valid_r <= 1'b0;
        end
    end

    // Registered write port; a register-0 winner uses the slot silently.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_addr <= 5'd0;
            wr_data <= 32'd0;
        end else begin
            wr_en <= win_valid_s & (win_addr_s != 5'd0);
            if (win_valid_s) begin
                wr_addr <= win_addr_s;
                wr_data <= win_data_s;
            end
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (err_set_s) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_addr;
    logic        ld_full;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        hazard;
    logic [31:0] pending;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;

    regfile_write_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_issue  (ld_issue),
        .ld_addr   (ld_addr),
        .ld_full   (ld_full),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .hazard    (hazard),
        .pending   (pending),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [4:0]  ret_addr [0:3];
        logic [31:0] ret_data [0:3];
        ret_addr[0] = 5'd2;  ret_data[0] = 32'h22;
        ret_addr[1] = 5'd3;  ret_data[1] = 32'h33;
        ret_addr[2] = 5'd4;  ret_data[2] = 32'h44;
        ret_addr[3] = 5'd6;  ret_data[3] = 32'h66;

        reset = 1'b0; alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
        ld_issue = 1'b0; ld_addr = 5'd0; ld_valid = 1'b0; ld_data = 32'd0;
        rs_addr = 5'd0; rt_addr = 5'd0;

        // Reset state
        #3;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_ld_full", {31'd0, ld_full}, 32'd0);
        check("rst_hazard", {31'd0, hazard}, 32'd0);
        check("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        step(); step();
        reset = 1'b1;
        step();

        // Plain ALU path
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
        #1;
        check("alu_ready_plain", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 1'b0;
        check("alu_wr_en", {31'd0, wr_en}, 32'd1);
        check("alu_wr_addr", {27'd0, wr_addr}, 32'd5);
        check("alu_wr_data", wr_data, 32'h1234);
        rs_addr = 5'd5;
        #1;
        check("hazard_wr_then_rd", {31'd0, hazard}, 32'd1);
        rs_addr = 5'd0;
        step();
        check("alu_idle_wr_en", {31'd0, wr_en}, 32'd0);

        // Collision between load return and ALU request
        ld_issue = 1'b1; ld_addr = 5'd7;
        step();
        ld_issue = 1'b0; rt_addr = 5'd7; alu_addr = 5'd7;
        #1;
        check("col_pending7", pending, 32'h80);
        check("col_hazard_rt", {31'd0, hazard}, 32'd1);
        check("col_alu_blocked", {31'd0, alu_ready}, 32'd0);
        rt_addr = 5'd0;
        ld_valid = 1'b1; ld_data = 32'hAA;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hBB;
        #1;
        check("col_alu_ready_pre", {31'd0, alu_ready}, 32'd1);
        step();
        ld_valid = 1'b0; alu_valid = 1'b0; rs_addr = 5'd3;
        #1;
        check("col_wr1_en", {31'd0, wr_en}, 32'd1);
        check("col_wr1_addr", {27'd0, wr_addr}, 32'd7);
        check("col_wr1_data", wr_data, 32'hAA);
        check("col_alu_ready_skid", {31'd0, alu_ready}, 32'd0);
        check("col_pending_clear", pending, 32'd0);
        check("col_hazard_skid", {31'd0, hazard}, 32'd1);
        step();
        check("col_wr2_en", {31'd0, wr_en}, 32'd1);
        check("col_wr2_addr", {27'd0, wr_addr}, 32'd3);
        check("col_wr2_data", wr_data, 32'hBB);
        check("col_alu_ready_post", {31'd0, alu_ready}, 32'd1);
        rs_addr = 5'd0;
        step();
        check("col_idle", {31'd0, wr_en}, 32'd0);

        // Scoreboard and hazard on register 9
        ld_issue = 1'b1; ld_addr = 5'd9;
        step();
        ld_issue = 1'b0; rs_addr = 5'd9;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h5555;
        #1;
        check("sb_hazard", {31'd0, hazard}, 32'd1);
        check("sb_pending9", pending, 32'h200);
        check("sb_alu_blocked", {31'd0, alu_ready}, 32'd0);
        step();
        check("sb_no_write", {31'd0, wr_en}, 32'd0);
        check("sb_alu_still_blocked", {31'd0, alu_ready}, 32'd0);
        ld_valid = 1'b1; ld_data = 32'h99;
        step();
        ld_valid = 1'b0;
        check("sb_ret_addr", {27'd0, wr_addr}, 32'd9);
        check("sb_ret_data", wr_data, 32'h99);
        check("sb_pending_clear", pending, 32'd0);
        check("sb_alu_ready", {31'd0, alu_ready}, 32'd1);
        check("sb_hazard_wr", {31'd0, hazard}, 32'd1);
        step();
        alu_valid = 1'b0;
        check("sb_alu_wr_en", {31'd0, wr_en}, 32'd1);
        check("sb_alu_wr_data", wr_data, 32'h5555);
        rs_addr = 5'd0;
        step();

        // Register 0 never written
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hDEAD;
        step();
        alu_valid = 1'b0;
        check("r0_alu_wr_en", {31'd0, wr_en}, 32'd0);
        ld_issue = 1'b1; ld_addr = 5'd0;
        step();
        ld_issue = 1'b0;
        check("r0_pending", pending, 32'd0);
        check("r0_hazard", {31'd0, hazard}, 32'd0);
        ld_valid = 1'b1; ld_data = 32'h77;
        step();
        ld_valid = 1'b0;
        check("r0_ld_wr_en", {31'd0, wr_en}, 32'd0);
        check("r0_err", {31'd0, err}, 32'd0);

        // FIFO limits
        for (int i = 1; i <= 4; i++) begin
            ld_issue = 1'b1; ld_addr = 5'(i);
            step();
        end
        ld_issue = 1'b0;
        check("fifo_full", {31'd0, ld_full}, 32'd1);
        check("fifo_pending4", pending, 32'h1E);
        ld_issue = 1'b1; ld_addr = 5'd6; ld_valid = 1'b1; ld_data = 32'h11;
        step();
        ld_issue = 1'b0; ld_valid = 1'b0;
        check("fifo_swap_wr_addr", {27'd0, wr_addr}, 32'd1);
        check("fifo_swap_wr_data", wr_data, 32'h11);
        check("fifo_swap_full", {31'd0, ld_full}, 32'd1);
        check("fifo_swap_err", {31'd0, err}, 32'd0);
        check("fifo_swap_pending", pending, 32'h5C);
        ld_issue = 1'b1; ld_addr = 5'd5;
        step();
        ld_issue = 1'b0;
        check("fifo_ovf_err", {31'd0, err}, 32'd1);
        check("fifo_ovf_pending", pending, 32'h5C);
        check("fifo_ovf_no_write", {31'd0, wr_en}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = ret_data[i];
            step();
            check("fifo_ret_en", {31'd0, wr_en}, 32'd1);
            check("fifo_ret_addr", {27'd0, wr_addr}, {27'd0, ret_addr[i]});
            check("fifo_ret_data", wr_data, ret_data[i]);
        end
        ld_data = 32'hEE;
        step();
        ld_valid = 1'b0;
        check("fifo_extra_no_write", {31'd0, wr_en}, 32'd0);
        check("fifo_empty_pending", pending, 32'd0);
        check("fifo_empty_full", {31'd0, ld_full}, 32'd0);

        // Reset mid-flight
        for (int i = 10; i <= 12; i++) begin
            ld_issue = 1'b1; ld_addr = 5'(i);
            step();
        end
        ld_issue = 1'b0;
        ld_valid = 1'b1; ld_data = 32'hA0;
        alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'hC0;
        step();
        ld_valid = 1'b0; alu_valid = 1'b0;
        check("mid_wr_addr", {27'd0, wr_addr}, 32'd10);
        check("mid_skid_full", {31'd0, alu_ready}, 32'd0);
        check("mid_pending", pending, 32'h1800);
        #1;
        reset = 1'b0; rs_addr = 5'd11;
        #1;
        check("arst_wr_en", {31'd0, wr_en}, 32'd0);
        check("arst_wr_addr", {27'd0, wr_addr}, 32'd0);
        check("arst_wr_data", wr_data, 32'd0);
        check("arst_pending", pending, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        check("arst_ld_full", {31'd0, ld_full}, 32'd0);
        check("arst_hazard", {31'd0, hazard}, 32'd0);
        check("arst_alu_ready", {31'd0, alu_ready}, 32'd1);
        step(); step();
        reset = 1'b1; rs_addr = 5'd0;
        ld_valid = 1'b1; ld_data = 32'hF0;
        step();
        ld_valid = 1'b0;
        check("post_rst_no_write", {31'd0, wr_en}, 32'd0);
        check("post_rst_err", {31'd0, err}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
